rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline write-back path;
  - a long-latency unit (multi-cycle mul/div return).
- Registered grant stage: winner's {we, waddr, wdata} and pc are captured and drive the RF write port, the ID-stage forwarding bus and the trace debug interface one cycle later.
- Fixed pipeline priority, bounded by a starvation counter; same-register ordering is preserved.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid long-op request may lose before it is forced to win (1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline write-back request valid
- pipe_ready  out  1  pipeline request accepted this cycle (pipeline allowin)
- pipe_rf_zip  in  38  {we, waddr[4:0], wdata[31:0]} from pipeline
- pipe_pc  in  32  pc of pipeline instruction
- lop_valid  in  1  long-op result valid
- lop_ready  out  1  long-op result accepted this cycle
- lop_rf_zip  in  38  {we, waddr, wdata} from long-op unit
- lop_pc  in  32  pc of long-op instruction
- rf_zip  out  38  registered {we, waddr, wdata} to register file / ID forwarding
- debug_wb_pc  out  32  registered pc of granted request
- debug_wb_rf_we  out  4  {4{rf_zip we}}
- debug_wb_rf_wnum  out  5  rf_zip waddr
- debug_wb_rf_wdata  out  32  rf_zip wdata

Behaviour:
- Reset: out_valid=0, rf_zip=0, debug_wb_pc=0, starve_cnt=0, pipe_ready=0, lop_ready=0.
- Grant is combinational from current inputs; at most one grant per cycle.
  - pipe_ready = grant_pipe; lop_ready = grant_lop.
  - The transfer happens when valid & ready are both high.
- Priority, evaluated in order:
  1. Only one requester valid: it wins.
  2. Both valid, both we=1, same nonzero waddr: long-op wins (it is older), so the WAW order is kept.
  3. Both valid and starve_cnt >= STARVE_LIMIT: long-op wins.
  4. Otherwise the pipeline wins.
- starve_cnt:
  - increments (saturating at 2^CNT_W-1) when lop_valid & ~grant_lop;
  - clears to 0 on grant_lop or when lop_valid=0.
- Output stage, on clk edge:
  - If a grant occurs: out_valid<=1, rf_zip<=winner zip with we forced 0 when waddr==0, debug_wb_pc<=winner pc.
  - Else: out_valid<=0 and rf_zip.we<=0; addr, data and pc hold their values.
- debug_wb_rf_we = {4{rf_zip.we}}.
  - Requests with we=0 still take a grant slot (one retire per cycle on the trace) but produce no RF write.
- Latency:
  - exactly 1 cycle from accepted request to rf_zip / debug outputs;
  - sustained throughput of 1 grant per cycle.
- Input stability: the loser's valid and zip must stay stable until its ready; the block does not buffer losers.
- Reset while a request is pending: no grant that cycle, outputs clear next edge, starve_cnt=0.
- Requester raises valid on the cycle reset deasserts: arbitrated normally that cycle.
- No combinational path from rf_zip back to pipe_ready/lop_ready.

Decomposition:
- Shared package (cpu_pkg):
  - RF_ZIP_W=38, RF_ADDR_W=5, DATA_W=32;
  - zip field offsets: WE bit 37, WADDR bits 36:32, WDATA bits 31:0.
- One natural sub-module: rf_wport_grant
  - combinational priority and WAW logic, plus the starvation counter register;
  - the parent holds the output stage and trace mapping.

Test Plan:
- pipe only: pipe_valid=1, zip={1,5'd3,32'h1234}, pc=32'h1c000000 -> pipe_ready=1 same cycle; next cycle rf_zip={1,3,0x1234}, debug_wb_rf_we=4'hf, debug_wb_pc=0x1c000000.
- Both valid, different regs (pipe r3, lop r7), STARVE_LIMIT=4, held 6 cycles -> pipe wins cycles 0-3; lop_ready=1 on cycle 4; r7 write appears on cycle 5; starve_cnt returns to 0.
- Both valid, same reg r9 (lop data 0xAAAA, pipe 0xBBBB) -> lop granted first; r9 written 0xAAAA then 0xBBBB on consecutive cycles.
- Write to r0: pipe zip={1,0,0xdead} -> next cycle rf_zip.we=0, debug_wb_rf_we=0, debug_wb_pc updated.
- Reset mid-stream: assert reset while both valid -> both readies 0; next cycle debug_wb_rf_we=0, starve_cnt=0; after release pipe wins the first cycle.
- we=0 request: pipe zip={0,5'd4,x} -> grant consumed, no RF write, debug_wb_pc updated, lop_valid waits one cycle.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, zip field offsets and helpers for the register-file write-port arbiter.
// The "zip" is the packed {we, waddr, wdata} word that travels from each requester to the RF.
package rf_wport_arbiter_pkg;

  localparam int RF_ZIP_W  = 38;
  localparam int RF_ADDR_W = 5;
  localparam int DATA_W    = 32;
  localparam int WE_BIT    = 37;
  localparam int WADDR_HI  = 36;
  localparam int WADDR_LO  = 32;
  localparam int WDATA_HI  = 31;

  typedef logic [RF_ZIP_W-1:0]  rf_zip_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0]    rf_data_t;

  function automatic logic zip_we(input rf_zip_t z);
    return z[WE_BIT];
  endfunction

  function automatic rf_addr_t zip_waddr(input rf_zip_t z);
    return z[WADDR_HI:WADDR_LO];
  endfunction

  function automatic rf_data_t zip_wdata(input rf_zip_t z);
    return z[WDATA_HI:0];
  endfunction

  // r0 is hardwired to zero, so a write aimed at it is demoted to a no-op slot.
  function automatic rf_zip_t zip_mask_r0(input rf_zip_t z);
    return {z[WE_BIT] & (z[WADDR_HI:WADDR_LO] != '0), z[WADDR_HI:0]};
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundles the two requester handshakes, the registered RF write port and the trace outputs.
// The slave modport is the arbiter's view; the master modport is the requesters' and observers' view.
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic        pipe_valid;
  logic        pipe_ready;
  rf_zip_t     pipe_rf_zip;
  logic [31:0] pipe_pc;
  logic        lop_valid;
  logic        lop_ready;
  rf_zip_t     lop_rf_zip;
  logic [31:0] lop_pc;
  logic        out_valid;
  rf_zip_t     rf_zip;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  rf_addr_t    debug_wb_rf_wnum;
  rf_data_t    debug_wb_rf_wdata;

  modport slave (
    input  pipe_valid, pipe_rf_zip, pipe_pc, lop_valid, lop_rf_zip, lop_pc,
    output pipe_ready, lop_ready, out_valid, rf_zip,
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output pipe_valid, pipe_rf_zip, pipe_pc, lop_valid, lop_rf_zip, lop_pc,
    input  pipe_ready, lop_ready, out_valid, rf_zip,
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/rf_wport_arbiter_grant.sv
// Combinational grant selection between pipeline and long-op requesters,
// plus the counter that bounds how long a valid long-op result can be starved.
module rf_wport_arbiter_grant
  import rf_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_valid,
  input  logic             pipe_we,
  input  rf_addr_t         pipe_waddr,
  input  logic             lop_valid,
  input  logic             lop_we,
  input  rf_addr_t         lop_waddr,
  output logic             grant_pipe,
  output logic             grant_lop,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic same_reg;

  // The long-op instruction is older, so on a same-register collision it must write first.
  assign same_reg = pipe_we && lop_we && (pipe_waddr == lop_waddr) && (pipe_waddr != '0);

  always_comb begin
    grant_pipe = 1'b0;
    grant_lop  = 1'b0;
    if (!reset) begin
      if (lop_valid && (!pipe_valid || same_reg || (starve_cnt >= LIMIT))) begin
        grant_lop = 1'b1;
      end else if (pipe_valid) begin
        grant_pipe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (lop_valid && !grant_lop) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single RF write port between pipeline write-back and the long-op return path.
// The winner is registered for one cycle and drives the RF, ID forwarding and trace outputs.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic               clk,
  input logic               reset,
  rf_wport_arbiter_if.slave bus
);

  logic             grant_pipe;
  logic             grant_lop;
  logic [CNT_W-1:0] starve_cnt;
  rf_zip_t          win_zip;
  logic [31:0]      win_pc;
  logic             out_valid_q;
  rf_zip_t          rf_zip_q;
  logic [31:0]      pc_q;

  rf_wport_arbiter_grant #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .pipe_valid(bus.pipe_valid),
    .pipe_we   (zip_we(bus.pipe_rf_zip)),
    .pipe_waddr(zip_waddr(bus.pipe_rf_zip)),
    .lop_valid (bus.lop_valid),
    .lop_we    (zip_we(bus.lop_rf_zip)),
    .lop_waddr (zip_waddr(bus.lop_rf_zip)),
    .grant_pipe(grant_pipe),
    .grant_lop (grant_lop),
    .starve_cnt(starve_cnt)
  );

  always_comb begin
    win_zip = bus.pipe_rf_zip;
    win_pc  = bus.pipe_pc;
    if (grant_lop) begin
      win_zip = bus.lop_rf_zip;
      win_pc  = bus.lop_pc;
    end
  end

  // On idle cycles only we drops; addr/data/pc hold so the forwarding bus stays quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rf_zip_q    <= '0;
      pc_q        <= '0;
    end else if (grant_pipe || grant_lop) begin
      out_valid_q <= 1'b1;
      rf_zip_q    <= zip_mask_r0(win_zip);
      pc_q        <= win_pc;
    end else begin
      out_valid_q      <= 1'b0;
      rf_zip_q[WE_BIT] <= 1'b0;
    end
  end

  assign bus.pipe_ready        = grant_pipe;
  assign bus.lop_ready         = grant_lop;
  assign bus.out_valid         = out_valid_q;
  assign bus.rf_zip            = rf_zip_q;
  assign bus.debug_wb_pc       = pc_q;
  assign bus.debug_wb_rf_we    = {4{zip_we(rf_zip_q)}};
  assign bus.debug_wb_rf_wnum  = zip_waddr(rf_zip_q);
  assign bus.debug_wb_rf_wdata = zip_wdata(rf_zip_q);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level model of grants, starvation and the registered write port.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  // model of the registered outputs and of consecutive long-op losses
  int          m_starve = 0;
  bit          m_valid = 0;
  rf_zip_t     m_zip = '0;
  logic [31:0] m_pc = '0;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic rf_zip_t mk(input bit we, input int addr, input logic [31:0] data);
    return {we, 5'(addr), data};
  endfunction

  // One clock: drive at negedge, check readies, clock, check registered outputs.
  task automatic drive_cycle(input bit rst, input bit pv, input rf_zip_t pz, input logic [31:0] ppc,
                             input bit lv, input rf_zip_t lz, input logic [31:0] lpc,
                             output bit gp, output bit gl);
    bit eg_p, eg_l;
    @(negedge clk);
    reset = rst;
    bus.pipe_valid = pv; bus.pipe_rf_zip = pz; bus.pipe_pc = ppc;
    bus.lop_valid = lv;  bus.lop_rf_zip = lz;  bus.lop_pc = lpc;
    #1;
    eg_p = 0; eg_l = 0;
    if (!rst) begin
      if (pv && lv) begin
        if ((pz[37] && lz[37] && pz[36:32] == lz[36:32] && pz[36:32] != 0) || m_starve >= LIMIT) eg_l = 1;
        else eg_p = 1;
      end else begin
        eg_p = pv;
        eg_l = lv;
      end
    end
    gp = bus.pipe_ready; gl = bus.lop_ready;
    total++;
    if (gp !== eg_p) begin bad++; $display("FAIL pipe_ready got %0b exp %0b @%0t", gp, eg_p, $time); end
    total++;
    if (gl !== eg_l) begin bad++; $display("FAIL lop_ready got %0b exp %0b @%0t", gl, eg_l, $time); end
    if (rst) begin
      m_starve = 0; m_valid = 0; m_zip = '0; m_pc = '0;
    end else begin
      m_starve = (lv && !eg_l) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
      if (eg_p || eg_l) begin
        m_valid = 1;
        m_zip = eg_l ? lz : pz;
        if (m_zip[36:32] == 0) m_zip[37] = 0;
        m_pc = eg_l ? lpc : ppc;
      end else begin
        m_valid = 0;
        m_zip[37] = 0;
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== m_valid) begin bad++; $display("FAIL out_valid got %0b exp %0b @%0t", bus.out_valid, m_valid, $time); end
    total++;
    if (bus.rf_zip !== m_zip) begin bad++; $display("FAIL rf_zip got %h exp %h @%0t", bus.rf_zip, m_zip, $time); end
    total++;
    if (bus.debug_wb_pc !== m_pc) begin bad++; $display("FAIL debug_wb_pc got %h exp %h @%0t", bus.debug_wb_pc, m_pc, $time); end
    total++;
    if (bus.debug_wb_rf_we !== {4{m_zip[37]}}) begin bad++; $display("FAIL debug_wb_rf_we got %h exp %h @%0t", bus.debug_wb_rf_we, {4{m_zip[37]}}, $time); end
    total++;
    if (bus.debug_wb_rf_wnum !== m_zip[36:32] || bus.debug_wb_rf_wdata !== m_zip[31:0]) begin
      bad++; $display("FAIL debug_wnum_wdata got %0d/%h exp %0d/%h @%0t", bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata, m_zip[36:32], m_zip[31:0], $time);
    end
    total++;
    if (int'(dut.u_grant.starve_cnt) != m_starve) begin bad++; $display("FAIL starve_cnt got %0d exp %0d @%0t", dut.u_grant.starve_cnt, m_starve, $time); end
  endtask

  task automatic idle(input bit rst);
    bit gp, gl;
    drive_cycle(rst, 0, '0, '0, 0, '0, '0, gp, gl);
  endtask

  task automatic test_reset();
    idle(1);
    idle(1);
    total++;
    if (bus.rf_zip !== '0 || bus.debug_wb_pc !== '0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got zip=%h pc=%h v=%0b exp 0", bus.rf_zip, bus.debug_wb_pc, bus.out_valid);
    end
    idle(0);
  endtask

  task automatic test_pipe_only();
    bit gp, gl;
    drive_cycle(0, 1, mk(1, 3, 32'h1234), 32'h1c000000, 0, '0, '0, gp, gl);
    total++;
    if (bus.rf_zip !== mk(1, 3, 32'h1234) || bus.debug_wb_rf_we !== 4'hf || bus.debug_wb_pc !== 32'h1c000000) begin
      bad++; $display("FAIL pipe_only got zip=%h we=%h pc=%h exp %h f 1c000000", bus.rf_zip, bus.debug_wb_rf_we, bus.debug_wb_pc, mk(1, 3, 32'h1234));
    end
    idle(0);
  endtask

  task automatic test_starvation();
    bit gp, gl, done;
    done = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 1, mk(1, 3, 32'h300 + i), 32'h1c000100 + 4 * i, !done, mk(1, 7, 32'h7777), 32'h1c000080, gp, gl);
      total++;
      if (gl !== (i == 4)) begin bad++; $display("FAIL starve_cycle%0d lop_ready got %0b exp %0b", i, gl, (i == 4)); end
      if (gl) begin
        done = 1;
        total++;
        if (bus.debug_wb_rf_wnum !== 5'd7 || bus.debug_wb_rf_wdata !== 32'h7777) begin
          bad++; $display("FAIL starve_lop_write got r%0d=%h exp r7=7777", bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata);
        end
      end
    end
    idle(0);
  endtask

  task automatic test_waw();
    bit gp, gl;
    drive_cycle(0, 1, mk(1, 9, 32'hBBBB), 32'h1c000200, 1, mk(1, 9, 32'hAAAA), 32'h1c0001f0, gp, gl);
    total++;
    if (!gl || bus.debug_wb_rf_wnum !== 5'd9 || bus.debug_wb_rf_wdata !== 32'hAAAA) begin
      bad++; $display("FAIL waw_first got gl=%0b r%0d=%h exp lop r9=AAAA", gl, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata);
    end
    drive_cycle(0, 1, mk(1, 9, 32'hBBBB), 32'h1c000200, 0, '0, '0, gp, gl);
    total++;
    if (!gp || bus.debug_wb_rf_wdata !== 32'hBBBB || bus.debug_wb_rf_we !== 4'hf) begin
      bad++; $display("FAIL waw_second got gp=%0b data=%h we=%h exp BBBB f", gp, bus.debug_wb_rf_wdata, bus.debug_wb_rf_we);
    end
    idle(0);
  endtask

  task automatic test_r0();
    bit gp, gl;
    drive_cycle(0, 1, mk(1, 0, 32'hdead), 32'h1c000300, 0, '0, '0, gp, gl);
    total++;
    if (bus.rf_zip[37] !== 1'b0 || bus.debug_wb_rf_we !== 4'h0 || bus.debug_wb_pc !== 32'h1c000300) begin
      bad++; $display("FAIL r0_write got we=%h pc=%h exp 0 1c000300", bus.debug_wb_rf_we, bus.debug_wb_pc);
    end
    idle(0);
  endtask

  task automatic test_reset_mid();
    bit gp, gl;
    for (int i = 0; i < 2; i++)
      drive_cycle(0, 1, mk(1, 3, 32'h33), 32'h1c000400, 1, mk(1, 7, 32'h77), 32'h1c0003f0, gp, gl);
    drive_cycle(1, 1, mk(1, 3, 32'h33), 32'h1c000400, 1, mk(1, 7, 32'h77), 32'h1c0003f0, gp, gl);
    total++;
    if (gp || gl || bus.debug_wb_rf_we !== 4'h0 || dut.u_grant.starve_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_mid got gp=%0b gl=%0b we=%h cnt=%0d exp 0 0 0 0", gp, gl, bus.debug_wb_rf_we, dut.u_grant.starve_cnt);
    end
    drive_cycle(0, 1, mk(1, 3, 32'h33), 32'h1c000400, 1, mk(1, 7, 32'h77), 32'h1c0003f0, gp, gl);
    total++;
    if (!gp || gl) begin bad++; $display("FAIL reset_release got gp=%0b gl=%0b exp 1 0", gp, gl); end
    drive_cycle(0, 0, '0, '0, 1, mk(1, 7, 32'h77), 32'h1c0003f0, gp, gl);
    idle(0);
  endtask

  task automatic test_we0();
    bit gp, gl;
    drive_cycle(0, 1, mk(0, 4, $urandom), 32'h1c000500, 1, mk(1, 6, 32'h66), 32'h1c0004f0, gp, gl);
    total++;
    if (!gp || bus.debug_wb_rf_we !== 4'h0 || bus.debug_wb_pc !== 32'h1c000500 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL we0_slot got gp=%0b we=%h pc=%h v=%0b exp 1 0 1c000500 1", gp, bus.debug_wb_rf_we, bus.debug_wb_pc, bus.out_valid);
    end
    drive_cycle(0, 0, '0, '0, 1, mk(1, 6, 32'h66), 32'h1c0004f0, gp, gl);
    total++;
    if (!gl || bus.debug_wb_rf_wnum !== 5'd6) begin bad++; $display("FAIL we0_lop_next got gl=%0b r%0d exp 1 r6", gl, bus.debug_wb_rf_wnum); end
    idle(0);
  endtask

  task automatic test_random();
    bit gp, gl, pv, lv, rst;
    rf_zip_t pz, lz;
    logic [31:0] ppc, lpc;
    pv = 0; lv = 0; pz = '0; lz = '0; ppc = 32'h1c001000; lpc = 32'h1c002000;
    for (int i = 0; i < 400; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pz = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
        ppc = ppc + 4;
      end
      if (!lv) begin
        lv = ($urandom_range(0, 2) != 0);
        lz = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
        lpc = lpc + 4;
      end
      rst = ($urandom_range(0, 49) == 0);
      drive_cycle(rst, pv, pz, ppc, lv, lz, lpc, gp, gl);
      if (gp) pv = 0;
      if (gl) lv = 0;
    end
    idle(0);
  endtask

  initial begin
    bus.pipe_valid = 0; bus.pipe_rf_zip = '0; bus.pipe_pc = '0;
    bus.lop_valid = 0;  bus.lop_rf_zip = '0;  bus.lop_pc = '0;
    test_reset();
    test_pipe_only();
    test_starvation();
    test_waw();
    test_r0();
    test_reset_mid();
    test_we0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
